// File: rtl/divider_if.sv
// Request/response bundle for the 32-bit RISC-V M-extension divider.
// The master drives operands and the start request; the slave (divider) returns the result.
interface divider_if;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_is_signed;
  logic        i_is_rem;
  logic        i_valid_input;
  logic [31:0] o_result;
  logic        o_valid_output;
  logic        o_busy;
  logic        o_completing_next_cycle;

  modport master (
    output i_dividend, i_divisor, i_is_signed, i_is_rem, i_valid_input,
    input  o_result, o_valid_output, o_busy, o_completing_next_cycle
  );

  modport slave (
    input  i_dividend, i_divisor, i_is_signed, i_is_rem, i_valid_input,
    output o_result, o_valid_output, o_busy, o_completing_next_cycle
  );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: 34-cycle normal path, 1-cycle special cases.
// Define DIVIDER_RESULT_CACHE_EN to add a one-entry cache of the last completed normal divide.
module divider (
  input  logic     i_clk,
  input  logic     i_rst_n,
  divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        is_rem_q, is_rem_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        comp_q, comp_d;

  logic        div_by_zero, overflow, cache_hit, fast_path, start_calc;
  logic [31:0] mag_dividend, mag_divisor;
  logic [32:0] shifted, diff;
  logic [31:0] fix_quot, fix_rem;
  logic [31:0] cache_quot, cache_rem;

  assign div_by_zero  = (bus.i_divisor == 32'd0);
  assign overflow     = bus.i_is_signed && (bus.i_dividend == 32'h8000_0000) &&
                        (bus.i_divisor == 32'hFFFF_FFFF);
  assign fast_path    = div_by_zero || overflow || cache_hit;
  assign start_calc   = (state_q == IDLE) && bus.i_valid_input && !fast_path;

  // Magnitudes are unsigned, so |-2^31| is simply 0x80000000.
  assign mag_dividend = (bus.i_is_signed && bus.i_dividend[31]) ? (~bus.i_dividend + 32'd1)
                                                                : bus.i_dividend;
  assign mag_divisor  = (bus.i_is_signed && bus.i_divisor[31]) ? (~bus.i_divisor + 32'd1)
                                                               : bus.i_divisor;

  // Partial remainder is widened to 33 bits so the trial subtract borrow lands in bit 32.
  assign shifted  = {rem_q, dvd_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign fix_quot = quo_neg_q ? (~dvd_q + 32'd1) : dvd_q;
  assign fix_rem  = rem_neg_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid_input) begin
          is_rem_d = bus.i_is_rem;
          if (div_by_zero) begin
            result_d = bus.i_is_rem ? bus.i_dividend : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = bus.i_is_rem ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else if (cache_hit) begin
            result_d = bus.i_is_rem ? cache_rem : cache_quot;
            state_d  = DONE;
          end else begin
            state_d   = CALC;
            count_d   = 5'd31;
            dvd_d     = mag_dividend;
            dvs_d     = mag_divisor;
            rem_d     = 32'd0;
            quo_neg_d = bus.i_is_signed && (bus.i_dividend[31] ^ bus.i_divisor[31]);
            rem_neg_d = bus.i_is_signed && bus.i_dividend[31];
          end
        end
      end
      CALC: begin
        // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
        rem_d   = diff[32] ? shifted[31:0] : diff[31:0];
        dvd_d   = {dvd_q[30:0], ~diff[32]};
        count_d = count_q - 5'd1;
        if (count_q == 5'd0) state_d = FIX;
      end
      FIX: begin
        result_d = is_rem_q ? fix_rem : fix_quot;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    comp_d  = (state_d == FIX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= 32'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      comp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      comp_q    <= comp_d;
    end
  end

`ifdef DIVIDER_RESULT_CACHE_EN
  logic [31:0] op_dividend_q, op_dividend_d;
  logic [31:0] op_divisor_q, op_divisor_d;
  logic        op_signed_q, op_signed_d;
  logic [31:0] c_dividend_q, c_dividend_d;
  logic [31:0] c_divisor_q, c_divisor_d;
  logic        c_signed_q, c_signed_d;
  logic [31:0] c_quot_q, c_quot_d;
  logic [31:0] c_rem_q, c_rem_d;
  logic        c_valid_q, c_valid_d;

  assign cache_hit  = c_valid_q && (c_dividend_q == bus.i_dividend) &&
                      (c_divisor_q == bus.i_divisor) && (c_signed_q == bus.i_is_signed);
  assign cache_quot = c_quot_q;
  assign cache_rem  = c_rem_q;

  // Raw operands are kept for the tag; the entry is written when FIX has both signed results.
  always_comb begin
    op_dividend_d = op_dividend_q;
    op_divisor_d  = op_divisor_q;
    op_signed_d   = op_signed_q;
    c_dividend_d  = c_dividend_q;
    c_divisor_d   = c_divisor_q;
    c_signed_d    = c_signed_q;
    c_quot_d      = c_quot_q;
    c_rem_d       = c_rem_q;
    c_valid_d     = c_valid_q;
    if (start_calc) begin
      op_dividend_d = bus.i_dividend;
      op_divisor_d  = bus.i_divisor;
      op_signed_d   = bus.i_is_signed;
    end
    if (state_q == FIX) begin
      c_dividend_d = op_dividend_q;
      c_divisor_d  = op_divisor_q;
      c_signed_d   = op_signed_q;
      c_quot_d     = fix_quot;
      c_rem_d      = fix_rem;
      c_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_dividend_q <= 32'd0;
      op_divisor_q  <= 32'd0;
      op_signed_q   <= 1'b0;
      c_dividend_q  <= 32'd0;
      c_divisor_q   <= 32'd0;
      c_signed_q    <= 1'b0;
      c_quot_q      <= 32'd0;
      c_rem_q       <= 32'd0;
      c_valid_q     <= 1'b0;
    end else begin
      op_dividend_q <= op_dividend_d;
      op_divisor_q  <= op_divisor_d;
      op_signed_q   <= op_signed_d;
      c_dividend_q  <= c_dividend_d;
      c_divisor_q   <= c_divisor_d;
      c_signed_q    <= c_signed_d;
      c_quot_q      <= c_quot_d;
      c_rem_q       <= c_rem_d;
      c_valid_q     <= c_valid_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_quot = 32'd0;
  assign cache_rem  = 32'd0;
`endif

  assign bus.o_result                = result_q;
  assign bus.o_valid_output          = valid_q;
  assign bus.o_busy                  = busy_q;
  assign bus.o_completing_next_cycle = comp_q ||
    (i_rst_n && (state_q == IDLE) && bus.i_valid_input && fast_path);

endmodule
